// File: rtl/int_pow_pkg.sv
// Shared types and IEEE-754 single-precision constants for the
// integer-power unit and its multiplier.
package int_pow_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic [31:0] FP_ONE     = 32'h3F800000;
    localparam int          FP_BIAS    = 127;
    localparam int          FP_EXP_MAX = 254;

    localparam int SIGN_W = 1;
    localparam int EXP_FW = 8;
    localparam int MAN_W  = 23;

endpackage

// File: rtl/int_pow_fp_if.sv
// Request/response bundle between the split stage and the power unit.
interface int_pow_fp_if #(
    parameter int EXP_W = 8
);
    logic             start;
    logic [31:0]      base;
    logic [EXP_W-1:0] int_n;
    logic [31:0]      result;
    logic             done;
    logic             busy;
    logic             ovf;

    modport master (
        output start, base, int_n,
        input  result, done, busy, ovf
    );

    modport slave (
        input  start, base, int_n,
        output result, done, busy, ovf
    );
endinterface

// File: rtl/int_pow_fp_fp_mul.sv
// Combinational truncating single-precision multiplier.
// INT_POW_SAT_EN: overflow saturates to signed infinity and is flagged.
module fp_mul
    import int_pow_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] p_o,
    output logic        ovf_o
);
    localparam logic signed [9:0] E_BIAS = 10'(FP_BIAS);

    logic                    sign;
    logic [EXP_FW-1:0]       ea;
    logic [EXP_FW-1:0]       eb;
    logic [47:0]             ma;
    logic [47:0]             mb;
    logic [24:0]             prod_hi;
    logic                    norm;
    logic [MAN_W-1:0]        man;
    logic signed [9:0]       e;
    logic                    zero_op;
    logic                    ovf;

    assign sign    = a_i[31] ^ b_i[31];
    assign ea      = a_i[30:23];
    assign eb      = b_i[30:23];
    assign ma      = {24'd0, 1'b1, a_i[22:0]};
    assign mb      = {24'd0, 1'b1, b_i[22:0]};
    // Low product bits are discarded: round toward zero.
    assign prod_hi = 25'((ma * mb) >> 23);
    assign norm    = prod_hi[24];
    assign man     = norm ? prod_hi[23:1] : prod_hi[22:0];
    assign e       = $signed({2'b00, ea}) + $signed({2'b00, eb})
                   + $signed({9'd0, norm}) - E_BIAS;
    assign zero_op = (ea == '0) || (eb == '0);

    always_comb begin
        ovf = 1'b0;
        if (zero_op || e < 10'sd1) begin
            p_o = {sign, 31'd0};
        end else begin
            p_o = {sign, e[7:0], man};
        end
`ifdef INT_POW_SAT_EN
        ovf = !zero_op && (ea == 8'hFF || eb == 8'hFF
                           || e > 10'(FP_EXP_MAX));
        if (ovf) begin
            p_o = {sign, 8'hFF, 23'd0};
        end
`endif
        ovf_o = ovf;
    end
endmodule

// File: rtl/int_pow_fp.sv
// x^n by LSB-first square-and-multiply, one bit of n per cycle.
// INT_POW_SAT_EN selects saturating overflow with an ovf flag.
module int_pow_fp
    import int_pow_pkg::*;
#(
    parameter int EXP_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    int_pow_fp_if.slave   ctl_io
);
    state_e           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      sq_q, sq_d;
    logic [EXP_W-1:0] rem_q, rem_d;
    logic             sqovf_q, sqovf_d;
    logic             accovf_q, accovf_d;
    logic [31:0]      result_q, result_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      acc_p, sq_p;
    logic             acc_p_ovf, sq_p_ovf;
    logic [31:0]      acc_nx;
    logic             accovf_nx;
    logic [EXP_W-1:0] rem_nx;

    fp_mul u_acc_mul (
        .a_i   (acc_q),
        .b_i   (sq_q),
        .p_o   (acc_p),
        .ovf_o (acc_p_ovf)
    );

    fp_mul u_sq_mul (
        .a_i   (sq_q),
        .b_i   (sq_q),
        .p_o   (sq_p),
        .ovf_o (sq_p_ovf)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sq_d      = sq_q;
        rem_d     = rem_q;
        sqovf_d   = sqovf_q;
        accovf_d  = accovf_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        rem_nx    = rem_q >> 1;
        acc_nx    = acc_q;
        accovf_nx = accovf_q;
        unique case (state_q)
            IDLE: begin
                if (ctl_io.start) begin
                    acc_d    = FP_ONE;
                    sq_d     = ctl_io.base;
                    rem_d    = ctl_io.int_n;
                    sqovf_d  = 1'b0;
                    accovf_d = 1'b0;
                    ovf_d    = 1'b0;
                    if (ctl_io.int_n == '0) begin
                        result_d = FP_ONE;
                        state_d  = DONE;
                    end else begin
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                // A stale sq overflow only matters once acc consumes it.
                if (rem_q[0]) begin
                    acc_nx    = acc_p;
                    accovf_nx = accovf_q | acc_p_ovf | sqovf_q;
                end
                acc_d    = acc_nx;
                accovf_d = accovf_nx;
                sq_d     = sq_p;
                sqovf_d  = sqovf_q | sq_p_ovf;
                rem_d    = rem_nx;
                if (rem_nx == '0) begin
                    result_d = acc_nx;
                    ovf_d    = accovf_nx;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            sq_q     <= '0;
            rem_q    <= '0;
            sqovf_q  <= 1'b0;
            accovf_q <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            sq_q     <= sq_d;
            rem_q    <= rem_d;
            sqovf_q  <= sqovf_d;
            accovf_q <= accovf_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ctl_io.result = result_q;
    assign ctl_io.done   = (state_q == DONE);
    assign ctl_io.busy   = (state_q != IDLE);
    assign ctl_io.ovf    = ovf_q;
endmodule
